decoder_64b: RTL and testbench
==============================

# decoder_64b

Binary-to-one-hot decoder: a 6-bit index on a valid-qualified input stream becomes a 64-bit one-hot word on a valid-qualified output stream. It is a leaf datapath utility in the math library. Typical consumers are bit-select logic, write-enable fan-out and bitmap set/clear paths. Parameter REG_OUT selects a registered output (one-cycle latency) or a purely combinational output (zero latency).

## Interface
- REG_OUT, default 1, 1 = output registered on clk_i; 0 = combinational path, no storage.
- clk_i  input  1  system clock, rising-edge active.
- rst_i  input  1  reset; asynchronous, active-high.
- in_data_i  input  6  binary index, 0..63.
- in_valid_i  input  1  qualifies in_data_i; no backpressure.
- out_data_o  output  64  one-hot decode of the index.
- out_valid_o  output  1  qualifies out_data_o.

## Operation
- Decode is out_data_o[k] = 1 iff k == in_data_i, for k = 0..63; exactly one bit set per valid beat.
- Structure:
  - Two 3-to-8 predecoders: low on in_data_i[2:0], high on in_data_i[5:3].
  - Each predecoder is gated by in_valid_i.
  - Bit k = hi[k[5:3]] AND lo[k[2:0]], built as an 8x8 AND plane.
  - Generate loops are permitted.
- Data gating: when in_valid_i = 0, the decoded word is all zeros. out_data_o is never nonzero while out_valid_o = 0.
- No ready signal. Every input cycle with in_valid_i = 1 produces exactly one output beat. Back-to-back beats are sustained at one per clock indefinitely.
- All 6-bit input values are legal; there is no out-of-range case.
- REG_OUT = 1:
  - On each rising edge, out_valid_o <= in_valid_i.
  - On the same edge, out_data_o <= gated decode of in_data_i.
- REG_OUT = 0:
  - out_valid_o = in_valid_i, combinational.
  - out_data_o = gated decode, combinational.
  - clk_i and rst_i are unused; no flops are inferred.
- Unknown (X) in_data_i while in_valid_i = 0 must not propagate to out_data_o, because the gating forces zeros.

## Timing
- Reset (REG_OUT = 1):
  - rst_i = 1 forces out_valid_o = 0 and out_data_o = 64'h0 immediately, without waiting for a clock edge.
  - Outputs hold these values while rst_i is high.
- The first edge after rst_i falls captures the inputs normally.
- Latency with REG_OUT = 1: input sampled at edge N appears at outputs after edge N and is stable until edge N+1. Throughput is 1 beat per cycle.
- Latency with REG_OUT = 0: 0 cycles. Outputs follow inputs within the combinational delay.
- Valid deassertion: in_valid_i = 0 at edge N gives out_valid_o = 0 and out_data_o = 0 after edge N. There is no hold-last-value behaviour.
- Reset mid-stream: an asserted beat is discarded. Outputs go to 0 asynchronously, and no beat is emitted for inputs presented while rst_i = 1.
- Wrap-around: index 63 followed by index 0 on consecutive cycles gives 64'h8000_0000_0000_0000 then 64'h1 on consecutive cycles, with no bubble.
- Single-cycle valid pulses and valid held continuously are both supported. Each edge is independent; there is no internal state beyond the output register.

## Test plan
- Reset: hold rst_i = 1 with in_valid_i = 1 and in_data_i = 6'd5 -> out_valid_o = 0 and out_data_o = 64'h0 throughout reset.
- Full sweep, REG_OUT = 1: in_valid_i = 1 with in_data_i = 0..63 on consecutive cycles -> one cycle later, out_data_o = 64'h1 << i and out_valid_o = 1 for 64 consecutive cycles. Check exactly one bit set each cycle.
- Valid drop: after the sweep, set in_valid_i = 0 with in_data_i = 63 -> next cycle out_valid_o = 0 and out_data_o = 64'h0.
- Mid-stream reset: while streaming index 10, assert rst_i between clock edges -> outputs go to 0 before the next edge. Release rst_i with index 11 valid -> out_data_o = 64'h800 one cycle later.
- Boundaries: indices 63, 0, 7, 8, 56 back-to-back -> 64'h8000_0000_0000_0000, 64'h1, 64'h80, 64'h100, 64'h0100_0000_0000_0000. This covers wrap-around and the predecoder crossings.
- REG_OUT = 0: in_data_i = 6'd33 with in_valid_i = 1 -> out_data_o = 64'h2_0000_0000 and out_valid_o = 1 in the same cycle. in_valid_i = 0 -> both zero in the same cycle.

Source files
------------

// File: rtl/decoder_64b.sv
// 6-bit index to 64-bit one-hot decoder, valid-gated, with optional output register.
// Built from two 3-to-8 predecoders feeding an 8x8 AND plane.
module decoder_64b #(
    parameter int unsigned REG_OUT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  in_data_i,
    input  logic        in_valid_i,
    output logic [63:0] out_data_o,
    output logic        out_valid_o
);

    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [63:0] dec;

    // Gating at the predecoders keeps X on in_data_i out of the word while invalid.
    always_comb begin
        lo = '0;
        hi = '0;
        if (in_valid_i) begin
            lo[in_data_i[2:0]] = 1'b1;
            hi[in_data_i[5:3]] = 1'b1;
        end
    end

    for (genvar h = 0; h < 8; h++) begin : g_hi
        for (genvar l = 0; l < 8; l++) begin : g_lo
            assign dec[h*8 + l] = hi[h] & lo[l];
        end
    end

    if (REG_OUT != 0) begin : g_reg
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                out_valid_o <= 1'b0;
                out_data_o  <= '0;
            end else begin
                out_valid_o <= in_valid_i;
                out_data_o  <= dec;
            end
        end
    end else begin : g_comb
        assign out_valid_o = in_valid_i;
        assign out_data_o  = dec;
    end

endmodule

// File: tb/tb_decoder_64b.sv
// Self-checking bench for decoder_64b: registered instance driven from vector tables
// and hand sequences, plus a combinational instance checked in the same cycle.
module tb_decoder_64b;

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [5:0]  in_data;
    logic        in_valid;
    logic [63:0] out_data;
    logic        out_valid;

    logic [5:0]  c_data;
    logic        c_valid;
    logic [63:0] c_out_data;
    logic        c_out_valid;

    int unsigned total;
    int unsigned passed;

    vec_t sweep [64];
    vec_t bound [5];

    decoder_64b #(.REG_OUT(1)) u_reg (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .out_data_o (out_data),
        .out_valid_o(out_valid)
    );

    decoder_64b #(.REG_OUT(0)) u_comb (
        .clk_i      (clk),
        .rst_i      (1'b0),
        .in_data_i  (c_data),
        .in_valid_i (c_valid),
        .out_data_o (c_out_data),
        .out_valid_o(c_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'd5;
        c_valid  = 1'b0;
        c_data   = 6'd0;

        for (int i = 0; i < 64; i++) begin
            sweep[i].idx = 6'(i);
            sweep[i].exp = 64'h1 << i;
        end
        bound[0] = '{6'd63, 64'h8000_0000_0000_0000};
        bound[1] = '{6'd0,  64'h0000_0000_0000_0001};
        bound[2] = '{6'd7,  64'h0000_0000_0000_0080};
        bound[3] = '{6'd8,  64'h0000_0000_0000_0100};
        bound[4] = '{6'd56, 64'h0100_0000_0000_0000};

        #2;
        check("reset_async_valid", {63'd0, out_valid}, 64'd0);
        check("reset_async_data", out_data, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold_valid", {63'd0, out_valid}, 64'd0);
            check("reset_hold_data", out_data, 64'h0);
        end

        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = sweep[i].idx;
            step();
            check($sformatf("sweep_data[%0d]", i), out_data, sweep[i].exp);
            check($sformatf("sweep_valid[%0d]", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("sweep_onehot[%0d]", i), 64'($countones(out_data)), 64'd1);
        end

        in_valid = 1'b0;
        in_data  = 6'd63;
        step();
        check("drop_valid", {63'd0, out_valid}, 64'd0);
        check("drop_data", out_data, 64'h0);

        in_valid = 1'b1;
        in_data  = 6'd10;
        step();
        check("mid_pre_data", out_data, 64'h400);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_valid", {63'd0, out_valid}, 64'd0);
        check("mid_async_data", out_data, 64'h0);
        step();
        check("mid_hold_data", out_data, 64'h0);
        check("mid_hold_valid", {63'd0, out_valid}, 64'd0);
        rst     = 1'b0;
        in_data = 6'd11;
        step();
        check("mid_release_data", out_data, 64'h800);
        check("mid_release_valid", {63'd0, out_valid}, 64'd1);

        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = bound[i].idx;
            step();
            check($sformatf("bound_data[%0d]", i), out_data, bound[i].exp);
            check($sformatf("bound_valid[%0d]", i), {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("bound_end_valid", {63'd0, out_valid}, 64'd0);

        c_data  = 6'd33;
        c_valid = 1'b1;
        #1;
        check("comb_data", c_out_data, 64'h2_0000_0000);
        check("comb_valid", {63'd0, c_out_valid}, 64'd1);
        c_valid = 1'b0;
        c_data  = 'x;
        #1;
        check("comb_off_data", c_out_data, 64'h0);
        check("comb_off_valid", {63'd0, c_out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
